upload_arbiter: RTL and testbench

Packet-locked round-robin arbiter sharing the command processor's single upload channel between multiple handler upload streams (UART, SPI, future handlers). Sits between the handlers' `upload_*` outputs and the command processor's `upload_*_in` / `upload_ready_out` pair. It replaces direct OR-merging of handler requests, guaranteeing that bytes from different sources never interleave and that every source gets a turn.

---
 rtl/upload_arbiter_if.sv | 31 +++
 rtl/upload_arbiter.sv | 150 +++++++++++++++
 tb/tb_upload_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upload_arbiter_if.sv
// rtl/upload_arbiter_if.sv - per-source upload streams and merged processor upload channel
interface upload_arbiter_if #(
    parameter int NUM_SOURCES = 4
);
    logic [NUM_SOURCES-1:0]   src_upload_req;
    logic [8*NUM_SOURCES-1:0] src_upload_data;
    logic [8*NUM_SOURCES-1:0] src_upload_source;
    logic [NUM_SOURCES-1:0]   src_upload_valid;
    logic [NUM_SOURCES-1:0]   src_upload_ready;

    logic                     merged_upload_req;
    logic [7:0]               merged_upload_data;
    logic [7:0]               merged_upload_source;
    logic                     merged_upload_valid;
    logic                     merged_upload_ready;

    // Arbiter side: consumes the handler streams, drives the processor channel.
    modport slave (
        input  src_upload_req, src_upload_data, src_upload_source, src_upload_valid,
        input  merged_upload_ready,
        output src_upload_ready,
        output merged_upload_req, merged_upload_data, merged_upload_source, merged_upload_valid
    );

    modport master (
        output src_upload_req, src_upload_data, src_upload_source, src_upload_valid,
        output merged_upload_ready,
        input  src_upload_ready,
        input  merged_upload_req, merged_upload_data, merged_upload_source, merged_upload_valid
    );
endinterface

// File: rtl/upload_arbiter.sv
// rtl/upload_arbiter.sv - packet-locked round-robin arbiter for the shared upload channel
module upload_arbiter #(
    parameter int NUM_SOURCES    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    upload_arbiter_if.slave        up,
    output logic [NUM_SOURCES-1:0] grant_onehot,
    output logic                   busy,
    output logic                   timeout_pulse
);
    localparam int          IDX_W         = $clog2(NUM_SOURCES);
    localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LIMIT = (TIMEOUT_CYCLES > 65535) ? 16'hFFFF : 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]       last_ptr_q, last_ptr_d;
    logic [15:0]            idle_cnt_q, idle_cnt_d;
    logic [NUM_SOURCES-1:0] grant_onehot_q, grant_onehot_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;

    logic                   g_req;
    logic                   g_valid;
    logic [7:0]             g_data;
    logic [7:0]             g_source;
    logic                   beat;

    logic                   m_req;
    logic                   m_valid;
    logic [7:0]             m_data;
    logic [7:0]             m_source;
    logic [NUM_SOURCES-1:0] src_ready;
    logic                   tmo_pulse;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_ptr_q;
        cand       = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = IDX_W'((int'(last_ptr_q) + k) % NUM_SOURCES);
            if (!pick_found && up.src_upload_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign g_req    = up.src_upload_req[grant_idx_q];
    assign g_valid  = up.src_upload_valid[grant_idx_q];
    assign g_data   = up.src_upload_data[{grant_idx_q, 3'b000} +: 8];
    assign g_source = up.src_upload_source[{grant_idx_q, 3'b000} +: 8];

    // A falling req masks valid/ready so the closing byte never crosses the release.
    assign beat = (state_q == ST_GRANT) && g_req && g_valid && up.merged_upload_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_idx_q    <= '0;
            last_ptr_q     <= IDX_W'(NUM_SOURCES - 1);
            idle_cnt_q     <= '0;
            grant_onehot_q <= '0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            last_ptr_q     <= last_ptr_d;
            idle_cnt_q     <= idle_cnt_d;
            grant_onehot_q <= grant_onehot_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        last_ptr_d     = last_ptr_q;
        idle_cnt_d     = idle_cnt_q;
        grant_onehot_d = grant_onehot_q;
        m_req          = 1'b0;
        m_valid        = 1'b0;
        m_data         = 8'h00;
        m_source       = 8'h00;
        src_ready      = '0;
        tmo_pulse      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d        = ST_GRANT;
                    grant_idx_d    = pick_idx;
                    last_ptr_d     = pick_idx;
                    idle_cnt_d     = '0;
                    grant_onehot_d = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << pick_idx;
                end
            end

            ST_GRANT: begin
                m_req                  = g_req;
                m_valid                = g_req & g_valid;
                m_data                 = g_data;
                m_source               = g_source;
                src_ready[grant_idx_q] = g_req & up.merged_upload_ready;

                if (!g_req) begin
                    state_d        = ST_RELEASE;
                    grant_onehot_d = '0;
                end else if (TIMEOUT_EN && (idle_cnt_q == TIMEOUT_LIMIT)) begin
                    state_d        = ST_RELEASE;
                    grant_onehot_d = '0;
                    tmo_pulse      = 1'b1;
                end else if (beat) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != 16'hFFFF) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end

            ST_RELEASE: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end

            default: begin
                state_d        = ST_IDLE;
                grant_onehot_d = '0;
            end
        endcase
    end

    assign up.merged_upload_req    = m_req;
    assign up.merged_upload_valid  = m_valid;
    assign up.merged_upload_data   = m_data;
    assign up.merged_upload_source = m_source;
    assign up.src_upload_ready     = src_ready;

    assign grant_onehot  = grant_onehot_q;
    assign busy          = (state_q == ST_GRANT);
    assign timeout_pulse = tmo_pulse;
endmodule

// File: tb/tb_upload_arbiter.sv
// tb/tb_upload_arbiter.sv - self-checking bench for upload_arbiter
module tb_upload_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upload_arbiter_if #(.NUM_SOURCES(N)) bus ();
    logic [N-1:0] grant_onehot;
    logic         busy;
    logic         timeout_pulse;

    upload_arbiter #(.NUM_SOURCES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (bus.slave),
        .grant_onehot  (grant_onehot),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] valid;
        logic [7:0] d1;
        logic       rdy;
        logic [3:0] e_grant;
        logic       e_mreq;
        logic       e_mvalid;
        logic [7:0] e_mdata;
        logic [7:0] e_msrc;
        logic [3:0] e_srdy;
    } vec_t;
    vec_t vecs[9];

    // Source traffic generators
    bit         active[N];
    int         left[N];
    int         vprob[N];
    logic [7:0] seq[N];
    int         rdy_prob;
    int         mode;

    // Reference model: who owns the channel, how long the quiet gap still lasts
    int m_owner, m_gap, m_last, m_idle, cyc;

    // Observations of the DUT
    int         d_grant[$];
    int         d_gcyc[$];
    int         d_rcyc[$];
    int         d_bsrc[$];
    logic [7:0] d_bdat[$];
    logic [N-1:0] d_prev;
    int         pulses, busy_src3;

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_last = N - 1; m_idle = 0; cyc = 0;
        d_grant.delete(); d_gcyc.delete(); d_rcyc.delete(); d_bsrc.delete(); d_bdat.delete();
        d_prev = '0; pulses = 0; busy_src3 = 0; mode = 0; rdy_prob = 100;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; left[i] = 0; vprob[i] = 100; seq[i] = 8'(32 * i + 1);
        end
    endtask

    task automatic start_pkt(input int s, input int len, input int vp);
        active[s] = 1'b1; left[s] = len; vprob[s] = vp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.src_upload_req = '0; bus.src_upload_valid = '0;
        bus.src_upload_data = '0; bus.src_upload_source = '0;
        bus.merged_upload_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant_onehot, 0);
        check("rst_busy", busy, 0);
        check("rst_mreq", bus.merged_upload_req, 0);
        check("rst_srdy", bus.src_upload_ready, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        logic [N-1:0]   req, val, e_grant, e_srdy;
        logic [8*N-1:0] dat, sid;
        logic           rdy, e_busy, e_mreq, e_mval, e_tp, beat;
        logic [7:0]     e_mdat, e_msrc;
        int             o, c;
        for (int i = 0; i < N; i++)
            if (active[i] && left[i] == 0) active[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = active[i];
            val[i] = active[i] && left[i] > 0 && ($urandom_range(99) < vprob[i]);
            dat[8*i +: 8] = seq[i];
            sid[8*i +: 8] = 8'(16 + i);
        end
        rdy = ($urandom_range(99) < rdy_prob);
        bus.src_upload_req = req; bus.src_upload_valid = val;
        bus.src_upload_data = dat; bus.src_upload_source = sid;
        bus.merged_upload_ready = rdy;
        @(negedge clk);

        o = m_owner;
        e_grant = '0; e_busy = 0; e_mreq = 0; e_mval = 0; e_mdat = 0; e_msrc = 0;
        e_srdy = '0; e_tp = 0; beat = 0;
        if (o >= 0) begin
            e_grant = 4'b1 << o; e_busy = 1;
            e_mreq = req[o]; e_mval = req[o] & val[o];
            e_mdat = dat[8*o +: 8]; e_msrc = sid[8*o +: 8];
            e_srdy = (rdy && req[o]) ? (4'b1 << o) : 4'b0;
            e_tp = req[o] && (m_idle == T);
            beat = req[o] && val[o] && rdy;
        end
        check("grant", grant_onehot, e_grant);
        check("busy", busy, e_busy);
        check("mreq", bus.merged_upload_req, e_mreq);
        check("mvalid", bus.merged_upload_valid, e_mval);
        check("mdata", bus.merged_upload_data, e_mdat);
        check("msrc", bus.merged_upload_source, e_msrc);
        check("srdy", bus.src_upload_ready, e_srdy);
        check("tpulse", timeout_pulse, e_tp);

        if (grant_onehot != '0 && grant_onehot != d_prev)
            for (int i = 0; i < N; i++) if (grant_onehot[i]) begin d_grant.push_back(i); d_gcyc.push_back(cyc); end
        if (busy && !bus.merged_upload_req) d_rcyc.push_back(cyc);
        if (bus.merged_upload_valid && rdy) begin
            d_bsrc.push_back(int'(bus.merged_upload_source) - 16);
            d_bdat.push_back(bus.merged_upload_data);
        end
        d_prev = grant_onehot;
        if (pulses == 0 && busy && grant_onehot == 4'b1000) busy_src3++;
        if (timeout_pulse) pulses++;

        if (beat) begin left[o]--; seq[o]++; end
        if (o >= 0) begin
            if (!req[o] || m_idle == T) begin m_owner = -1; m_gap = 1; end
            else if (beat) m_idle = 0;
            else if (m_idle < 65535) m_idle++;
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c]) begin m_owner = c; m_last = c; m_idle = 0; end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!req[i] && !active[i]) begin
                if (mode == 1) start_pkt(i, 1, 100);
                else if (mode == 2 && $urandom_range(9) == 0)
                    start_pkt(i, int'($urandom_range(1, 5)), int'($urandom_range(0, 100)));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0010, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
        vecs[1] = '{4'b0010, 4'b1111, 8'hA1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 8'h11, 4'b0010};
        vecs[2] = '{4'b0010, 4'b1111, 8'hA2, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA2, 8'h11, 4'b0010};
        vecs[3] = '{4'b0010, 4'b1111, 8'hA3, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA3, 8'h11, 4'b0010};
        vecs[4] = '{4'b0010, 4'b0000, 8'hA3, 1'b0, 4'b0010, 1'b1, 1'b0, 8'hA3, 8'h11, 4'b0000};
        vecs[5] = '{4'b0000, 4'b0010, 8'hFF, 1'b1, 4'b0010, 1'b0, 1'b0, 8'hFF, 8'h11, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
        vecs[7] = '{4'b0010, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00, 4'b0000};
        vecs[8] = '{4'b0010, 4'b1101, 8'h00, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 8'h11, 4'b0010};

        do_reset();
        for (int v = 0; v < 9; v++) begin
            bus.src_upload_req = vecs[v].req;
            bus.src_upload_valid = vecs[v].valid;
            bus.src_upload_data = {8'hD3, 8'hD2, vecs[v].d1, 8'hD0};
            bus.src_upload_source = {8'h13, 8'h12, 8'h11, 8'h10};
            bus.merged_upload_ready = vecs[v].rdy;
            @(negedge clk);
            check($sformatf("v%0d_grant", v), grant_onehot, vecs[v].e_grant);
            check($sformatf("v%0d_busy", v), busy, |vecs[v].e_grant);
            check($sformatf("v%0d_mreq", v), bus.merged_upload_req, vecs[v].e_mreq);
            check($sformatf("v%0d_mvalid", v), bus.merged_upload_valid, vecs[v].e_mvalid);
            check($sformatf("v%0d_mdata", v), bus.merged_upload_data, vecs[v].e_mdata);
            check($sformatf("v%0d_msrc", v), bus.merged_upload_source, vecs[v].e_msrc);
            check($sformatf("v%0d_srdy", v), bus.src_upload_ready, vecs[v].e_srdy);
            @(posedge clk);
            #1;
        end

        // Simultaneous requests from 0 and 1
        do_reset();
        start_pkt(0, 2, 100); start_pkt(1, 2, 100);
        repeat (14) step();
        check("B_ngrant", d_grant.size(), 2);
        if (d_grant.size() >= 2 && d_rcyc.size() >= 1) begin
            check("B_first", d_grant[0], 0);
            check("B_second", d_grant[1], 1);
            check("B_gap", d_gcyc[1] - d_rcyc[0], 3);
        end
        check("B_nbeats", d_bsrc.size(), 4);
        if (d_bsrc.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("B_bsrc%0d", k), d_bsrc[k], k / 2);

        // Source 0 arrives mid-packet of source 2
        do_reset();
        start_pkt(2, 4, 100);
        repeat (3) step();
        start_pkt(0, 2, 100);
        repeat (14) step();
        check("C_ngrant", d_grant.size(), 2);
        if (d_grant.size() >= 2) begin
            check("C_first", d_grant[0], 2);
            check("C_second", d_grant[1], 0);
        end
        check("C_nbeats", d_bdat.size(), 6);
        if (d_bdat.size() == 6) begin
            for (int k = 0; k < 4; k++) check($sformatf("C_dat%0d", k), d_bdat[k], 8'h41 + k);
            check("C_dat4", d_bdat[4], 8'h01);
            check("C_dat5", d_bdat[5], 8'h02);
        end

        // All sources continuously requesting single-byte packets
        do_reset();
        mode = 1;
        for (int i = 0; i < N; i++) start_pkt(i, 1, 100);
        repeat (40) step();
        check("D_ngrant_ge8", d_grant.size() >= 8, 1);
        if (d_grant.size() >= 8)
            for (int k = 0; k < 8; k++) check($sformatf("D_order%0d", k), d_grant[k], k % 4);

        // Source 3 stalls with valid low until the timeout fires
        do_reset();
        start_pkt(3, 1, 0);
        repeat (3) step();
        start_pkt(1, 1, 100);
        repeat (27) step();
        check("E_pulses", pulses, 1);
        check("E_grant_len", busy_src3, T + 1);
        check("E_ngrant_ge2", d_grant.size() >= 2, 1);
        if (d_grant.size() >= 2) begin
            check("E_first", d_grant[0], 3);
            check("E_second", d_grant[1], 1);
        end

        // Asynchronous reset in the middle of a packet
        do_reset();
        rdy_prob = 50;
        start_pkt(0, 8, 100);
        repeat (4) step();
        check("F_pre_busy", busy, 1);
        #3;
        rst_n = 1'b0;
        bus.merged_upload_ready = ~bus.merged_upload_ready;
        #1;
        check("F_grant", grant_onehot, 0);
        check("F_busy", busy, 0);
        check("F_mreq", bus.merged_upload_req, 0);
        check("F_mvalid", bus.merged_upload_valid, 0);
        check("F_mdata", bus.merged_upload_data, 0);
        check("F_msrc", bus.merged_upload_source, 0);
        check("F_srdy", bus.src_upload_ready, 0);
        @(posedge clk);
        #1;
        bus.merged_upload_ready = ~bus.merged_upload_ready;
        check("F_hold_srdy", bus.src_upload_ready, 0);
        check("F_hold_mreq", bus.merged_upload_req, 0);
        rst_n = 1'b1;
        model_reset();
        start_pkt(2, 1, 100); start_pkt(0, 1, 100);
        repeat (10) step();
        check("F_ngrant", d_grant.size(), 2);
        if (d_grant.size() >= 2) begin
            check("F_first", d_grant[0], 0);
            check("F_second", d_grant[1], 2);
        end

        // Randomized traffic against the reference model
        do_reset();
        mode = 2;
        rdy_prob = 70;
        repeat (2500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
